// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: load-use, memory wait, branch.
// Memory-wait watchdog with sticky error and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_in,
    input  logic [4:0]       id_rs2_in,
    input  logic             id_use_rs1_in,
    input  logic             id_use_rs2_in,
    input  logic [4:0]       ex_rd_in,
    input  logic             ex_reg_wr_in,
    input  logic             ex_mem_rd_in,
    input  logic             ex_br_taken_in,
    input  logic             mem_req_in,
    input  logic             mem_ack_in,
    output logic             pc_stall_out,
    output logic             ifid_stall_out,
    output logic             ifid_flush_out,
    output logic             idex_stall_out,
    output logic             idex_flush_out,
    output logic             exmem_stall_out,
    output logic             memwb_flush_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out,
    output logic             timeout_err_out
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    state_e            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              err_q;

    logic lu, mw, rs1_hit, rs2_hit;

    assign rs1_hit = id_use_rs1_in && (id_rs1_in == ex_rd_in);
    assign rs2_hit = id_use_rs2_in && (id_rs2_in == ex_rd_in);
    assign lu = ex_mem_rd_in && ex_reg_wr_in && (ex_rd_in != 5'd0)
                && (rs1_hit || rs2_hit);
    assign mw = mem_req_in && !mem_ack_in;

    always_comb begin
        pc_stall_out    = 1'b0;
        ifid_stall_out  = 1'b0;
        ifid_flush_out  = 1'b0;
        idex_stall_out  = 1'b0;
        idex_flush_out  = 1'b0;
        exmem_stall_out = 1'b0;
        memwb_flush_out = 1'b0;
        if (!rst) begin
            if (state_q == ERR || mw) begin
                pc_stall_out    = 1'b1;
                ifid_stall_out  = 1'b1;
                idex_stall_out  = 1'b1;
                exmem_stall_out = 1'b1;
                memwb_flush_out = 1'b1;
            end else if (ex_br_taken_in) begin
                ifid_flush_out = 1'b1;
                idex_flush_out = 1'b1;
            end else if (lu) begin
                pc_stall_out   = 1'b1;
                ifid_stall_out = 1'b1;
                idex_flush_out = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_out && stall_cnt_q != {CNT_W{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (idex_flush_out && flush_cnt_q != {CNT_W{1'b1}})
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            unique case (state_q)
                RUN: begin
                    if (mw) begin
                        state_q <= MEM_WAIT;
                        wait_q  <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mw) begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ERR: state_q <= ERR;
                default: state_q <= RUN;
            endcase
        end
    end

    assign state_out       = state_q;
    assign stall_cnt_out   = stall_cnt_q;
    assign flush_cnt_out   = flush_cnt_q;
    assign timeout_err_out = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0, branch priority, memory wait,
// watchdog timeout and counter saturation (TIMEOUT_CYC=4, CNT_W=4).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       use_rs1, use_rs2, ex_reg_wr, ex_mem_rd, br;
    logic       mem_req, mem_ack;
    logic       pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_fl;
    logic [1:0] state;
    logic [3:0] stall_cnt, flush_cnt;
    logic       err;

    int total = 0;
    int fails = 0;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] FULL = 7'b1101011;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] BR   = 7'b0010100;

    logic [6:0] outs;
    assign outs = {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, memwb_fl};

    hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_in(id_rs1), .id_rs2_in(id_rs2),
        .id_use_rs1_in(use_rs1), .id_use_rs2_in(use_rs2),
        .ex_rd_in(ex_rd), .ex_reg_wr_in(ex_reg_wr), .ex_mem_rd_in(ex_mem_rd),
        .ex_br_taken_in(br), .mem_req_in(mem_req), .mem_ack_in(mem_ack),
        .pc_stall_out(pc_st), .ifid_stall_out(ifid_st), .ifid_flush_out(ifid_fl),
        .idex_stall_out(idex_st), .idex_flush_out(idex_fl),
        .exmem_stall_out(exmem_st), .memwb_flush_out(memwb_fl),
        .state_out(state), .stall_cnt_out(stall_cnt), .flush_cnt_out(flush_cnt),
        .timeout_err_out(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        use_rs1 = 0; use_rs2 = 0; ex_reg_wr = 0; ex_mem_rd = 0;
        br = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        // reset with a load-use present: outputs forced low
        ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 5; id_rs2 = 5; use_rs2 = 1;
        #2;
        chk("rst_outs", outs, NONE);
        tick();
        chk("rst_state", state, 2'b00);
        chk("rst_scnt", stall_cnt, 0);
        chk("rst_fcnt", flush_cnt, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        #1;

        // load-use on rs2
        chk("lu_outs", outs, LU);
        tick();
        ex_mem_rd = 0;
        #1;
        chk("lu_next", outs, NONE);
        chk("lu_scnt", stall_cnt, 1);
        chk("lu_fcnt", flush_cnt, 1);

        // x0 and unused operand
        clear_in();
        ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 0; id_rs1 = 0; use_rs1 = 1;
        #1;
        chk("x0_outs", outs, NONE);
        ex_rd = 7; id_rs1 = 7; use_rs1 = 0;
        #1;
        chk("unused_outs", outs, NONE);
        use_rs1 = 1;
        #1;
        chk("rs1_lu", outs, LU);
        ex_reg_wr = 0;
        #1;
        chk("no_wr", outs, NONE);
        ex_reg_wr = 1;

        // branch overrides load-use
        br = 1;
        #1;
        chk("br_outs", outs, BR);
        tick();
        chk("br_scnt", stall_cnt, 1);
        chk("br_fcnt", flush_cnt, 2);

        // memory wait: 3 stalled cycles then ack
        clear_in();
        do_reset();
        mem_req = 1;
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) br = 1;
            #1;
            chk($sformatf("mw_outs%0d", i), outs, FULL);
            tick();
            chk($sformatf("mw_state%0d", i), state, 2'b01);
        end
        br = 0;
        mem_ack = 1;
        #1;
        chk("ack_outs", outs, NONE);
        tick();
        chk("ack_state", state, 2'b00);
        chk("ack_scnt", stall_cnt, 3);
        chk("ack_fcnt", flush_cnt, 0);
        chk("ack_err", err, 0);

        // watchdog timeout
        clear_in();
        do_reset();
        mem_req = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("wd_state%0d", i), state, 2'b01);
        end
        chk("wd_err_pre", err, 0);
        tick();
        chk("wd_state4", state, 2'b10);
        chk("wd_err", err, 1);
        mem_req = 0;
        #1;
        chk("err_outs", outs, FULL);
        tick();
        chk("err_sticky", state, 2'b10);
        chk("err_scnt", stall_cnt, 5);
        rst = 1'b1;
        #1;
        chk("err_rst_outs", outs, NONE);
        tick();
        rst = 1'b0;
        #1;
        chk("rec_state", state, 2'b00);
        chk("rec_scnt", stall_cnt, 0);
        chk("rec_fcnt", flush_cnt, 0);
        chk("rec_err", err, 0);
        chk("rec_outs", outs, NONE);

        // saturation: 20 load-use cycles
        ex_mem_rd = 1; ex_reg_wr = 1; ex_rd = 9; id_rs1 = 9; use_rs1 = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_scnt", stall_cnt, 15);
        chk("sat_fcnt", flush_cnt, 15);
        chk("sat_outs", outs, LU);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
